// File: rtl/fft_loader.sv
// rtl/fft_loader.sv - sequencer that loads six operand bytes into fft and reads back NRES result bytes
// Optional abort input is enabled by defining FFT_LOADER_ABORT_EN.
module fft_loader #(
  parameter int GAP    = 2,
  parameter int NRES   = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        w1,
  input  logic [7:0]        w2,
  input  logic [7:0]        a1,
  input  logic [7:0]        a2,
  input  logic [7:0]        b1,
  input  logic [7:0]        b2,
  input  logic [7:0]        out,
`ifdef FFT_LOADER_ABORT_EN
  input  logic              abort,
`endif
  output logic [7:0]        inp,
  output logic              readyin,
  output logic [8*NRES-1:0] res,
  output logic              busy,
  output logic              done
);

  localparam int GW = $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [GW-1:0] CAP_AT   = GW'(RD_LAT - 1);
  localparam logic [2:0]    RD_LAST  = 3'(NRES - 1);

  typedef enum logic [2:0] {IDLE, LSTB, LGAP, RSTB, RGAP, DONE} state_t;

  state_t          state;
  logic [GW-1:0]   gcnt;
  logic [2:0]      wcnt;
  logic [2:0]      rcnt;
  logic [5:0][7:0] ops;
  logic            kill;

`ifdef FFT_LOADER_ABORT_EN
  assign kill = abort && (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gcnt    <= '0;
      wcnt    <= '0;
      rcnt    <= '0;
      ops     <= '0;
      inp     <= '0;
      readyin <= 1'b0;
      res     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (kill) begin
      state   <= IDLE;
      readyin <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      readyin <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Word 0 is strobed straight out of IDLE so the first strobe lands on cycle 1.
            ops     <= {b2, b1, a2, a1, w2, w1};
            inp     <= w1;
            readyin <= 1'b1;
            busy    <= 1'b1;
            wcnt    <= '0;
            rcnt    <= '0;
            gcnt    <= '0;
            state   <= LSTB;
          end
        end
        LSTB: begin
          state <= LGAP;
          gcnt  <= '0;
          wcnt  <= wcnt + 3'd1;
        end
        LGAP: begin
          if (gcnt == GAP_LAST) begin
            readyin <= 1'b1;
            if (wcnt == 3'd6) begin
              state <= RSTB;
            end else begin
              state <= LSTB;
              inp   <= ops[wcnt];
            end
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        RSTB: begin
          state <= RGAP;
          gcnt  <= '0;
        end
        RGAP: begin
          if (gcnt == CAP_AT) begin
            for (int k = 0; k < NRES; k++) begin
              if (rcnt == 3'(k)) res[8*k +: 8] <= out;
            end
          end
          if (gcnt == GAP_LAST) begin
            rcnt <= rcnt + 3'd1;
            if (rcnt == RD_LAST) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= RSTB;
              readyin <= 1'b1;
            end
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_loader.sv
// tb/tb_fft_loader.sv - self-checking bench for fft_loader against a cycle-schedule reference model
// Covers the abort input when FFT_LOADER_ABORT_EN is defined.
module tb_fft_loader;
  localparam int GAP    = 2;
  localparam int NRES   = 4;
  localparam int RD_LAT = 1;
  localparam int P      = GAP + 1;
  localparam int DONE_C = (6 + NRES) * P + 1;

  logic clk, rst, start;
  logic [7:0] w1, w2, a1, a2, b1, b2, out;
  logic [7:0] inp;
  logic readyin, busy, done;
  logic [8*NRES-1:0] res;
`ifdef FFT_LOADER_ABORT_EN
  logic abort;
`endif

  fft_loader #(.GAP(GAP), .NRES(NRES), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .w1(w1), .w2(w2), .a1(a1), .a2(a2), .b1(b1), .b2(b2),
    .out(out),
`ifdef FFT_LOADER_ABORT_EN
    .abort(abort),
`endif
    .inp(inp), .readyin(readyin), .res(res), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] mop [6];
  logic [7:0] mres [NRES];
  logic [7:0] rb [NRES];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_strobe(int c);
    return c >= 1 && (c - 1) % P == 0 && (c - 1) / P < 6 + NRES;
  endfunction

  function automatic logic [7:0] exp_inp(int c);
    int n;
    n = (c - 1) / P;
    if (n > 5) n = 5;
    return mop[n];
  endfunction

  function automatic int cap_cycle(int k);
    return 1 + (6 + k) * P + RD_LAT;
  endfunction

  function automatic logic [63:0] model_res();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < NRES; k++) v[8*k +: 8] = mres[k];
    return v;
  endfunction

  task automatic rand_ops();
    w1 = 8'($urandom); w2 = 8'($urandom); a1 = 8'($urandom);
    a2 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
    for (int k = 0; k < NRES; k++) rb[k] = 8'($urandom);
  endtask

  // Caller has start=1 and operands set at cycle 0; runs cycles 1..last.
  task automatic run_txn(input bit hold, input bit lockout, input int last);
    mop = '{w1, w2, a1, a2, b1, b2};
    for (int c = 1; c <= last; c++) begin
      step();
      if (!hold) start = 1'b0;
      if (lockout && c == 5) start = 1'b1;
      if (lockout && c == 6) begin
        if (!hold) start = 1'b0;
        w1 = ~w1; w2 = ~w2; a1 = ~a1; a2 = ~a2; b1 = ~b1; b2 = ~b2;
      end
      out = 8'($urandom);
      for (int k = 0; k < NRES; k++) if (c == cap_cycle(k)) out = rb[k];
      check($sformatf("readyin@%0d", c), 64'(readyin), 64'(is_strobe(c)));
      check($sformatf("inp@%0d", c), 64'(inp), 64'(exp_inp(c)));
      check($sformatf("busy@%0d", c), 64'(busy), 64'(c <= DONE_C));
      check($sformatf("done@%0d", c), 64'(done), 64'(c == DONE_C));
      check($sformatf("res@%0d", c), 64'(res), model_res());
      for (int k = 0; k < NRES; k++) if (c == cap_cycle(k)) mres[k] = rb[k];
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; out = 8'h00;
`ifdef FFT_LOADER_ABORT_EN
    abort = 1'b0;
`endif
    rand_ops();
    for (int k = 0; k < NRES; k++) mres[k] = 8'h00;

    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_readyin", 64'(readyin), 64'd0);
      check("rst_inp", 64'(inp), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_res", 64'(res), 64'd0);
    end
    start = 1'b0;
    rst = 1'b0;
    step();
    step();
    check("idle_readyin", 64'(readyin), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    w1 = 8'h60; w2 = 8'hC0; a1 = 8'h02; a2 = 8'h03; b1 = 8'h05; b2 = 8'h06;
    rb[0] = 8'h11; rb[1] = 8'h22; rb[2] = 8'h33; rb[3] = 8'h44;
    start = 1'b1;
    run_txn(1'b0, 1'b1, DONE_C + 1);
    check("directed_res", 64'(res), 64'h44332211);

    for (int i = 0; i < 3; i++) begin
      rand_ops();
      start = 1'b1;
      run_txn(1'b0, i == 0, DONE_C + 1);
    end

    rand_ops();
    start = 1'b1;
    run_txn(1'b1, 1'b0, DONE_C + 1);
    rand_ops();
    run_txn(1'b1, 1'b1, DONE_C + 1);
    rand_ops();
    run_txn(1'b0, 1'b0, DONE_C + 1);

    rand_ops();
    start = 1'b1;
    run_txn(1'b0, 1'b0, 24);
    rst = 1'b1;
    #1;
    check("mrst_readyin", 64'(readyin), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_res", 64'(res), 64'd0);
    check("mrst_inp", 64'(inp), 64'd0);
    for (int k = 0; k < NRES; k++) mres[k] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      step();
      check("mrst_done", 64'(done), 64'd0);
      check("mrst_busy_hold", 64'(busy), 64'd0);
    end
    rst = 1'b0;
    step();
    check("post_rst_idle", 64'(busy), 64'd0);
    rand_ops();
    start = 1'b1;
    run_txn(1'b0, 1'b0, DONE_C + 1);

`ifdef FFT_LOADER_ABORT_EN
    rand_ops();
    start = 1'b1;
    run_txn(1'b0, 1'b0, 12);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_readyin", 64'(readyin), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_res", 64'(res), model_res());
    rand_ops();
    start = 1'b1;
    run_txn(1'b0, 1'b0, DONE_C + 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fft_loader.md
# fft_loader

Host-side initiator for the `fft` block's byte-serial `inp`/`readyin`/`out` interface. On `start`, it latches six operand bytes (w1, w2, a1, a2, b1, b2) and shifts them into `fft` one strobe at a time. It then issues `NRES` read strobes, captures each `out` byte into a result register, and pulses `done`. It sits between the control logic and the `fft` instance and replaces the hand-timed stimulus sequence with a synthesisable sequencer.

## Interface
- `GAP`, 2, idle cycles between consecutive `readyin` strobes (≥1)
- `NRES`, 4, number of result bytes read back (1–8)
- `RD_LAT`, 1, cycles from a read strobe to a valid `out` byte (1 ≤ RD_LAT ≤ GAP)
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous reset, active-high
- `start` in 1: begin a transaction; sampled only in IDLE
- `w1`, `w2`, `a1`, `a2`, `b1`, `b2` in 8 each: operands, sampled on the accepted `start` edge
- `out` in 8: result byte from `fft`
- `inp` out 8: operand byte to `fft`
- `readyin` out 1: one-cycle strobe to `fft`
- `res` out 8×NRES: captured results, packed with byte 0 in the LSBs
- `busy` out 1: high while state ≠ IDLE
- `done` out 1: one-cycle completion pulse

## Operation
- States: IDLE → LSTB → LGAP → (LSTB ×6) → RSTB → RGAP → (RSTB ×NRES) → DONE → IDLE.
- IDLE: when `start`=1, latch all six operands, clear word/read counters, go to LSTB.
- LSTB (one cycle):
  - `readyin`=1, `inp` = operand[word] in the order w1, w2, a1, a2, b1, b2.
  - Go to LGAP.
- LGAP:
  - `readyin`=0 for GAP cycles; `inp` holds its value.
  - Then go to LSTB if words remain, else RSTB.
- RSTB (one cycle):
  - `readyin`=1; `inp` holds b2.
  - Arm capture of read index k.
- RGAP:
  - `readyin`=0 for GAP cycles.
  - Exactly RD_LAT cycles after the RSTB cycle, `res[k]` ← `out`.
  - Then go to RSTB if reads remain, else DONE.
- DONE (one cycle): `done`=1, `busy`=1; go to IDLE.
- `start` is ignored in every state except IDLE. Operand changes while `busy`=1 have no effect.
- `res` bytes change only on their capture cycle and otherwise hold, including across transactions, until overwritten.
- The gap counter is log2(GAP+1) bits; the word counter is 3 bits; the read counter is 3 bits.

## Timing
- Reset values: `inp`=0, `readyin`=0, `res`=all 0, `busy`=0, `done`=0, state IDLE, all counters 0.
- Cycle numbering: `start` is accepted at cycle 0.
- Load strobes at cycles 1 + n(GAP+1), n=0..5. With GAP=2: cycles 1, 4, 7, 10, 13, 16.
- Read strobe k at cycle 1 + (6+k)(GAP+1). With defaults: cycles 19, 22, 25, 28.
- Captures at each read strobe + RD_LAT. With defaults: cycles 20, 23, 26, 29.
- `done` at cycle 1 + (6+NRES)(GAP+1) − 1 + 1. With defaults: cycle 31.
- `busy` is high for cycles 1..31 and low at cycle 32. A new `start` is accepted at cycle 32 at the earliest.
- `start` held high continuously produces back-to-back transactions, each beginning on the cycle after DONE.
- Mid-operation `rst`:
  - Outputs return to reset values immediately (asynchronously), including `res`.
  - No `done` is produced for the aborted transaction.
  - After `rst` falls, the block waits in IDLE for a fresh `start`.

## Configuration
- `FFT_LOADER_ABORT_EN`:
  - Defined: adds input `abort` (1 bit).
    - `abort`=1 in any non-IDLE state forces IDLE on the next edge, with `readyin`=0 and `busy`=0 on that edge.
    - No `done` is produced. `res` keeps the bytes already captured.
    - `abort` in IDLE is ignored.
    - When `abort` and `done` occur in the same cycle, `done` still completes.
  - Undefined: no `abort` port; transactions always run to completion.

## Test plan
- Reset: `rst`=1 mid-idle → all outputs 0; `start` while `rst`=1 → no strobe.
- Load sequence: `start` with w1=0x60, w2=0xC0, a1=0x02, a2=0x03, b1=0x05, b2=0x06 → `readyin` pulses at cycles 1, 4, 7, 10, 13, 16, with `inp` = 0x60, 0xC0, 0x02, 0x03, 0x05, 0x06 on those cycles and `readyin`=0 elsewhere.
- Readback: model `fft` drives `out` = 0x11, 0x22, 0x33, 0x44 one cycle after each read strobe → `res` = 0x44332211, `done` pulse only at cycle 31, `busy` falls at cycle 32.
- Busy lockout: `start` pulsed at cycle 5 and operands changed at cycle 6 → no extra strobes, `inp` stream unchanged.
- Reset mid-read: `rst` asserted at cycle 24 → `readyin`, `busy`, `res` = 0 immediately, no `done`; new `start` after release reruns the full sequence.
- `FFT_LOADER_ABORT_EN` build: `abort` at cycle 12 → `busy`=0 at cycle 13, no strobe at 13, no `done`; immediate `start` restarts from w1.
